// File: rtl/qam_sym_fifo.sv
// qam_sym_fifo: registered-output symbol FIFO; define QAM_SYM_FIFO_ERR_EN for sticky ovf/udf flags
module qam_sym_fifo #(
  parameter int DATA_W    = 6,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       udf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count_nxt;
  logic wr_acc, rd_acc;
  always_comb begin
    rd_acc    = rd_en & ~empty;
    wr_acc    = wr_en & (~full | rd_acc);
    count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
  end
  always_ff @(posedge clk)
    if (wr_acc) mem[wptr] <= wr_data;
  // flags are computed from the next count so they move on the same edge as count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      if (rd_acc) rd_data <= mem[rptr];
      rd_valid    <= rd_acc;
      count       <= count_nxt;
      full        <= count_nxt == CW'(DEPTH);
      empty       <= count_nxt == '0;
      almost_full <= count_nxt >= CW'(AF_THRESH);
    end
`ifdef QAM_SYM_FIFO_ERR_EN
  // a read on an empty FIFO with a simultaneous write is not an underflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en & ~wr_acc) ovf <= 1'b1;
      if (rd_en & empty & ~wr_en) udf <= 1'b1;
    end
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif
endmodule

// File: tb/tb_qam_sym_fifo.sv
// tb_qam_sym_fifo: table vectors, directed corner sequences and random traffic against a queue model
module tb_qam_sym_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic [5:0] wr_data = '0;
  logic rd_en = 1'b0;
  logic [5:0] rd_data;
  logic rd_valid, full, empty, almost_full, ovf, udf;
  logic [4:0] count;
  int checks = 0;
  int errors = 0;
  logic [5:0] q[$];
  logic [5:0] exp_data;
  logic exp_valid, exp_ovf, exp_udf;
  typedef struct {
    logic we;
    logic [5:0] wd;
    logic re;
    int cnt;
    logic vld;
    logic [5:0] dat;
  } vec_t;
  vec_t tbl[7];
  qam_sym_fifo #(.DATA_W(6), .DEPTH(16), .AF_THRESH(12)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .ovf(ovf), .udf(udf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("count", int'(count), q.size());
    chk("full", int'(full), int'(q.size() == 16));
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("almost_full", int'(almost_full), int'(q.size() >= 12));
    chk("rd_valid", int'(rd_valid), int'(exp_valid));
    chk("rd_data", int'(rd_data), int'(exp_data));
    chk("ovf", int'(ovf), int'(exp_ovf));
    chk("udf", int'(udf), int'(exp_udf));
  endtask
  task automatic model_clear();
    q.delete();
    exp_data = '0;
    exp_valid = 1'b0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic step(input logic we, input logic [5:0] wd, input logic re);
    bit was_full, was_empty, ra, wa;
    @(negedge clk);
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    was_full = q.size() == 16;
    was_empty = q.size() == 0;
    ra = re && !was_empty;
    wa = we && (!was_full || ra);
`ifdef QAM_SYM_FIFO_ERR_EN
    if (we && !wa) exp_ovf = 1'b1;
    if (re && was_empty && !we) exp_udf = 1'b1;
`endif
    exp_valid = ra;
    if (ra) exp_data = q.pop_front();
    if (wa) q.push_back(wd);
    @(posedge clk);
    #1;
    check_all();
  endtask
  initial begin
    tbl[0] = '{1'b1, 6'h15, 1'b1, 1, 1'b0, 6'h00};
    tbl[1] = '{1'b0, 6'h00, 1'b1, 0, 1'b1, 6'h15};
    tbl[2] = '{1'b0, 6'h00, 1'b1, 0, 1'b0, 6'h15};
    tbl[3] = '{1'b1, 6'h03, 1'b0, 1, 1'b0, 6'h15};
    tbl[4] = '{1'b1, 6'h07, 1'b0, 2, 1'b0, 6'h15};
    tbl[5] = '{1'b0, 6'h00, 1'b1, 1, 1'b1, 6'h03};
    tbl[6] = '{1'b1, 6'h09, 1'b1, 1, 1'b1, 6'h07};
    model_clear();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].we, tbl[i].wd, tbl[i].re);
      chk("tbl_count", int'(count), tbl[i].cnt);
      chk("tbl_valid", int'(rd_valid), int'(tbl[i].vld));
      chk("tbl_data", int'(rd_data), int'(tbl[i].dat));
    end
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 6'(i), 1'b0);
      chk("af_ramp", int'(almost_full), int'(i >= 12));
    end
    chk("full_at_16", int'(full), 1);
    for (int i = 0; i < 3; i++) step(1'b1, 6'h2A, 1'b1);
    chk("full_both", int'(count), 16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 6'h00, 1'b1);
      chk("order", int'(rd_data), i < 13 ? i + 4 : 6'h2A);
    end
    chk("empty_end", int'(empty), 1);
    for (int i = 0; i < 18; i++) step(1'b1, 6'(i + 20), 1'b0);
    step(1'b0, 6'h00, 1'b1);
    do_reset();
    chk("rst_count", int'(count), 0);
    step(1'b0, 6'h00, 1'b1);
    step(1'b0, 6'h00, 1'b1);
    step(1'b1, 6'h11, 1'b0);
    step(1'b0, 6'h00, 1'b1);
    chk("first_after_rst", int'(rd_data), 6'h11);
    for (int i = 0; i < 10; i++) step(1'b1, 6'($urandom), 1'b0);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int p;
      p = q.size() < 3 ? 85 : (q.size() > 13 ? 15 : 55);
      step($urandom_range(0, 99) < p, 6'($urandom), $urandom_range(0, 99) < 50);
    end
    for (int i = 0; i < 300; i++) step($urandom_range(0, 1) == 1, 6'($urandom), $urandom_range(0, 2) == 0);
    for (int i = 0; i < 300; i++) step($urandom_range(0, 2) == 0, 6'($urandom), $urandom_range(0, 1) == 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qam_sym_fifo.md
QAM_SYM_FIFO -- requirements
Module: qam_sym_fifo

Interface
REQ-001 Parameter DATA_W, default 6, symbol word width in bits (6 = one 64QAM symbol), legal 1..32.
REQ-002 Parameter DEPTH, default 16, storage entries, power of two, legal 4..256.
REQ-003 Parameter AF_THRESH, default 12, almost_full asserts when count >= AF_THRESH, legal 1..DEPTH.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  write request.
REQ-007 wr_data  input  DATA_W  write word.
REQ-008 rd_en  input  1  read request.
REQ-009 rd_data  output  DATA_W  registered read word.
REQ-010 rd_valid  output  1  rd_data holds a word popped on the previous cycle.
REQ-011 full / empty / almost_full  output  1 each  registered status flags.
REQ-012 count  output  log2(DEPTH)+1  registered occupancy, 0..DEPTH.
REQ-013 ovf / udf  output  1 each  sticky error flags (see Configuration).

Function
REQ-014 Write accepted iff wr_en=1 and (full=0 or read accepted same cycle); accepted word stored at write pointer, pointer increments mod DEPTH.
REQ-015 Read accepted iff rd_en=1 and empty=0; no write-to-read bypass when empty.
REQ-016 Read latency one cycle: rd_data and rd_valid=1 on the edge after acceptance; rd_valid=0 in cycles following no accepted read; rd_data holds its last value when rd_valid=0.
REQ-017 count: +1 write only, -1 read only, unchanged on both or neither.
REQ-018 full=1 iff count=DEPTH; empty=1 iff count=0; almost_full=1 iff count>=AF_THRESH; all flags updated same edge as count.
REQ-019 Full with wr_en and rd_en both high: both accepted, count stays DEPTH, full stays 1.
REQ-020 Empty with wr_en and rd_en both high: write accepted, read rejected, count becomes 1, rd_valid=0 next cycle.
REQ-021 Write while full without read: rejected, storage and pointers unchanged.
REQ-022 Read while empty: rejected, pointers unchanged, rd_valid=0.
REQ-023 Pointers wrap DEPTH-1 -> 0 with no data loss or reordering; output order strictly FIFO.

Reset
REQ-024 rst_n=0 asynchronously clears pointers, count=0, empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, ovf=0, udf=0.
REQ-025 Storage array not reset; contents unobservable until rewritten.
REQ-026 Reset mid-stream discards all held words; first accepted write after deassertion is the first word read.
REQ-027 Reset deassertion synchronous to clk by the integrator; no internal synchroniser.

Configuration
REQ-028 Macro QAM_SYM_FIFO_ERR_EN defined: ovf set to 1 on any rejected write (REQ-021), udf set to 1 on any rejected read while empty (REQ-022, excluding REQ-020 case); both stay 1 until reset.
REQ-029 Macro QAM_SYM_FIFO_ERR_EN undefined: ovf and udf tied to 0, no error-detect logic; all other behaviour identical.

Verification
REQ-030 Reset then write 0x01..0x10 (16 words, DEPTH=16) -> count=16, full=1, almost_full=1 from 12th write; read 16 -> rd_data 0x01..0x10 in order, each one cycle after rd_en, empty=1 at end.
REQ-031 Full, wr_en=rd_en=1 with wr_data=0x2A for 3 cycles -> count stays 16, full stays 1, 0x2A appears after the 16 original words.
REQ-032 Empty, wr_en=rd_en=1 with 0x15 -> count=1, rd_valid=0 next cycle; rd_en next cycle -> rd_data=0x15, rd_valid=1.
REQ-033 40 words through with interleaved writes/reads keeping count 3..14 -> pointers wrap twice, output sequence equals input sequence.
REQ-034 With QAM_SYM_FIFO_ERR_EN: write while full -> ovf=1 held; read while empty -> udf=1 held; rst_n pulse mid-stream -> both 0, count=0, empty=1 immediately.
REQ-035 Without QAM_SYM_FIFO_ERR_EN: same stimulus as REQ-034 -> ovf=udf=0 throughout, data behaviour unchanged.
